datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 45 ++++
 rtl/datapath_regfile.sv | 31 +++
 rtl/datapath.sv | 145 ++++++++++++++
 tb/tb_datapath.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - ALU op codes and datapath mux select encodings
package datapath_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_MOV  = 3'b101,
      ALU_MUL  = 3'b110,
      ALU_ZERO = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCA_REG    = 2'b00,
      SRCA_PC     = 2'b01,
      SRCA_ALUOUT = 2'b10,
      SRCA_ZERO   = 2'b11
   } srca_sel_t;

   typedef enum logic [1:0] {
      SRCB_WD   = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10,
      SRCB_ZERO = 2'b11
   } srcb_sel_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_DATA   = 2'b01,
      RES_ALU    = 2'b10,
      RES_ALU2   = 2'b11
   } res_sel_t;

   typedef enum logic [1:0] {
      IMM_8    = 2'b00,
      IMM_12   = 2'b01,
      IMM_BR   = 2'b10,
      IMM_NONE = 2'b11
   } imm_sel_t;

   localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - r0..r14 register file, address 15 reads the R15 input
module regfile
   import datapath_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we3,
   input  logic [3:0]  a1,
   input  logic [3:0]  a2,
   input  logic [3:0]  a3,
   input  logic [31:0] wd3,
   input  logic [31:0] r15,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] rf [0:14];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 15; i++) rf[i] <= 32'd0;
      end else if (we3 && a3 != PC_REG) begin
         rf[a3] <= wd3;
      end
   end

   // PC is not stored here; address 15 returns whatever the caller supplies
   assign rd1 = (a1 == PC_REG) ? r15 : rf[a1];
   assign rd2 = (a2 == PC_REG) ? r15 : rf[a2];

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - multicycle ARM-style datapath: PC, IR, regfile, ALU and result muxing
module datapath
   import datapath_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] Adr,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData,
   output logic [31:0] Instr,
   output logic [3:0]  ALUFlags,
   input  logic        PCWrite,
   input  logic        RegWrite,
   input  logic        IRWrite,
   input  logic        AdrSrc,
   input  logic [1:0]  RegSrc,
   input  logic [1:0]  ALUSrcA,
   input  logic [1:0]  ALUSrcB,
   input  logic [1:0]  ResultSrc,
   input  logic [1:0]  ImmSrc,
   input  logic [2:0]  ALUControl,
   output logic [31:0] PCNext,
   output logic [31:0] PC,
   output logic [31:0] ExtImm,
   output logic [31:0] SrcA,
   output logic [31:0] SrcB,
   output logic [31:0] Result,
   output logic [31:0] Data,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] A,
   output logic [31:0] ALUResult,
   output logic [31:0] ALUOut,
   output logic [3:0]  RA1,
   output logic [3:0]  RA2
);

   logic [32:0] sum;
   logic [31:0] addb;
   logic [31:0] product;
   logic        is_sub;
   logic        is_arith;
   logic        carry;
   logic        ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         PC        <= 32'd0;
         Instr     <= 32'd0;
         Data      <= 32'd0;
         A         <= 32'd0;
         WriteData <= 32'd0;
         ALUOut    <= 32'd0;
      end else begin
         if (PCWrite) PC    <= PCNext;
         if (IRWrite) Instr <= ReadData;
         Data      <= ReadData;
         A         <= RD1;
         WriteData <= RD2;
         ALUOut    <= ALUResult;
      end
   end

   assign PCNext = Result;
   assign Adr    = AdrSrc ? Result : PC;
   assign RA1    = RegSrc[0] ? PC_REG : Instr[19:16];
   assign RA2    = RegSrc[1] ? Instr[15:12] : Instr[3:0];

   regfile u_regfile (
      .clk   (clk),
      .reset (reset),
      .we3   (RegWrite),
      .a1    (RA1),
      .a2    (RA2),
      .a3    (Instr[15:12]),
      .wd3   (Result),
      .r15   (Result),
      .rd1   (RD1),
      .rd2   (RD2)
   );

   always_comb begin
      ExtImm = 32'd0;
      unique case (imm_sel_t'(ImmSrc))
         IMM_8:    ExtImm = {24'd0, Instr[7:0]};
         IMM_12:   ExtImm = {20'd0, Instr[11:0]};
         IMM_BR:   ExtImm = {{6{Instr[23]}}, Instr[23:0], 2'b00};
         default:  ExtImm = 32'd0;
      endcase
   end

   always_comb begin
      SrcA = 32'd0;
      unique case (srca_sel_t'(ALUSrcA))
         SRCA_REG:    SrcA = A;
         SRCA_PC:     SrcA = PC;
         SRCA_ALUOUT: SrcA = ALUOut;
         default:     SrcA = 32'd0;
      endcase
   end

   always_comb begin
      SrcB = 32'd0;
      unique case (srcb_sel_t'(ALUSrcB))
         SRCB_WD:   SrcB = WriteData;
         SRCB_IMM:  SrcB = ExtImm;
         SRCB_FOUR: SrcB = 32'd4;
         default:   SrcB = 32'd0;
      endcase
   end

   // One adder serves ADD and SUB; subtraction is A + ~B + 1 so carry means "no borrow"
   assign is_sub   = (alu_op_t'(ALUControl) == ALU_SUB);
   assign is_arith = (alu_op_t'(ALUControl) == ALU_ADD) || is_sub;
   assign addb     = is_sub ? ~SrcB : SrcB;
   assign sum      = {1'b0, SrcA} + {1'b0, addb} + {32'd0, is_sub};
   assign product  = SrcA * SrcB;

   always_comb begin
      ALUResult = 32'd0;
      unique case (alu_op_t'(ALUControl))
         ALU_ADD, ALU_SUB: ALUResult = sum[31:0];
         ALU_AND:          ALUResult = SrcA & SrcB;
         ALU_OR:           ALUResult = SrcA | SrcB;
         ALU_XOR:          ALUResult = SrcA ^ SrcB;
         ALU_MOV:          ALUResult = SrcB;
         ALU_MUL:          ALUResult = product;
         default:          ALUResult = 32'd0;
      endcase
   end

   assign carry    = is_arith & sum[32];
   assign ovf      = is_arith & (SrcA[31] == addb[31]) & (sum[31] != SrcA[31]);
   assign ALUFlags = {ALUResult[31], (ALUResult == 32'd0), carry, ovf};

   always_comb begin
      Result = ALUResult;
      unique case (res_sel_t'(ResultSrc))
         RES_ALUOUT: Result = ALUOut;
         RES_DATA:   Result = Data;
         default:    Result = ALUResult;
      endcase
   end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed self-checking bench for datapath
module tb_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Adr, WriteData, ReadData, Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [31:0] PCNext, PC, ExtImm, SrcA, SrcB, Result, Data, RD1, RD2, A, ALUResult, ALUOut;
   logic [3:0]  RA1, RA2;

   int n_checks = 0;
   int n_errors = 0;

   datapath dut (
      .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
      .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .PCNext(PCNext), .PC(PC), .ExtImm(ExtImm), .SrcA(SrcA), .SrcB(SrcB), .Result(Result),
      .Data(Data), .RD1(RD1), .RD2(RD2), .A(A), .ALUResult(ALUResult), .ALUOut(ALUOut),
      .RA1(RA1), .RA2(RA2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] res;
      logic [3:0]  flags;
   } alu_vec_t;

   alu_vec_t alu_vecs [8];

   initial begin
      // SrcA = 0x7FFFFFFF, SrcB = 1
      alu_vecs[0] = '{3'b000, 32'h8000_0000, 4'b1001};
      alu_vecs[1] = '{3'b001, 32'h7FFF_FFFE, 4'b0010};
      alu_vecs[2] = '{3'b010, 32'h0000_0001, 4'b0000};
      alu_vecs[3] = '{3'b011, 32'h7FFF_FFFF, 4'b0000};
      alu_vecs[4] = '{3'b100, 32'h7FFF_FFFE, 4'b0000};
      alu_vecs[5] = '{3'b101, 32'h0000_0001, 4'b0000};
      alu_vecs[6] = '{3'b110, 32'h7FFF_FFFF, 4'b0000};
      alu_vecs[7] = '{3'b111, 32'h0000_0000, 4'b0100};

      reset = 1'b1; ReadData = 32'd0;
      PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
      RegSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
      step();
      reset = 1'b0;
      #1;
      check("rst_pc", PC, 32'd0);
      check("rst_instr", Instr, 32'd0);
      check("rst_adr", Adr, 32'd0);
      check("rst_a", A, 32'd0);
      check("rst_aluout", ALUOut, 32'd0);
      check("rst_flags", {28'd0, ALUFlags}, 32'h4);

      // fetch
      ReadData = 32'hE280_1005; IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
      ALUControl = 3'b000; ResultSrc = 2'b10; PCWrite = 1;
      #1;
      check("fetch_pcnext", PCNext, 32'd4);
      check("fetch_adr", Adr, 32'd0);
      step();
      IRWrite = 0; PCWrite = 0;
      #1;
      check("fetch_instr", Instr, 32'hE280_1005);
      check("fetch_pc", PC, 32'd4);
      AdrSrc = 1;
      #1;
      check("adr_result", Adr, 32'd8);
      AdrSrc = 0;

      // decode
      RegSrc = 2'b00; ImmSrc = 2'b00;
      #1;
      check("dec_ra1", {28'd0, RA1}, 32'd0);
      check("dec_ra2", {28'd0, RA2}, 32'd5);
      check("dec_imm", ExtImm, 32'd5);
      step();

      // execute / writeback
      ALUSrcA = 2'b00; ALUSrcB = 2'b01; ALUControl = 3'b000;
      #1;
      check("exe_alu", ALUResult, 32'd5);
      step();
      check("exe_aluout", ALUOut, 32'd5);
      ResultSrc = 2'b00; RegWrite = 1;
      #1;
      check("wb_result", Result, 32'd5);
      step();
      RegWrite = 0; RegSrc = 2'b10;
      #1;
      check("wb_ra2", {28'd0, RA2}, 32'd1);
      check("wb_r1", RD2, 32'd5);

      // 5 - 5
      ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = 3'b001;
      #1;
      check("sub_alu", ALUResult, 32'd0);
      check("sub_flags", {28'd0, ALUFlags}, 32'h6);

      // r1 <- 0x7FFFFFFF, then A <- r1
      ReadData = 32'h0001_1001; IRWrite = 1;
      step();
      IRWrite = 0; ReadData = 32'h7FFF_FFFF;
      step();
      ResultSrc = 2'b01; RegWrite = 1;
      step();
      RegWrite = 0;
      step();
      check("ovf_a", A, 32'h7FFF_FFFF);
      ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00;
      for (int i = 0; i < 8; i++) begin
         ALUControl = alu_vecs[i].op;
         #1;
         check($sformatf("alu_res_op%0d", i), ALUResult, alu_vecs[i].res);
         check($sformatf("alu_flags_op%0d", i), {28'd0, ALUFlags}, {28'd0, alu_vecs[i].flags});
      end

      ALUSrcA = 2'b11; ALUSrcB = 2'b11;
      #1;
      check("srca_zero", SrcA, 32'd0);
      check("srcb_zero", SrcB, 32'd0);
      ALUSrcB = 2'b10;
      #1;
      check("srcb_four", SrcB, 32'd4);

      // branch immediate forms
      ReadData = 32'h0AFF_FFFE; IRWrite = 1;
      step();
      IRWrite = 0;
      ImmSrc = 2'b10;
      #1;
      check("imm_branch", ExtImm, 32'hFFFF_FFF8);
      ImmSrc = 2'b01;
      #1;
      check("imm_12", ExtImm, 32'h0000_0FFE);
      ImmSrc = 2'b11;
      #1;
      check("imm_none", ExtImm, 32'd0);

      // write to r15 must be dropped; RA1=15 reads back Result
      ReadData = 32'hDEAD_BEEF;
      step();
      ResultSrc = 2'b01; RegSrc = 2'b01;
      #1;
      check("r15_ra1", {28'd0, RA1}, 32'hF);
      check("r15_rd1", RD1, 32'hDEAD_BEEF);
      RegWrite = 1;
      step();
      RegWrite = 0;
      ReadData = 32'h0001_0000; IRWrite = 1;
      step();
      IRWrite = 0; RegSrc = 2'b00;
      #1;
      check("r15_keep_r1", RD1, 32'h7FFF_FFFF);
      check("r15_keep_r0", RD2, 32'd0);

      // reset beats enables
      reset = 1; PCWrite = 1; RegWrite = 1; IRWrite = 1;
      step();
      reset = 0; PCWrite = 0; RegWrite = 0; IRWrite = 0;
      #1;
      check("rst2_pc", PC, 32'd0);
      check("rst2_instr", Instr, 32'd0);
      check("rst2_aluout", ALUOut, 32'd0);
      check("rst2_data", Data, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
